// File: rtl/fetch_hazard_ctrl.sv
// Fetch/decode hazard controller: load-use stall, branch flush, BOOT hold and (FETCH_HALT_EN) debug drain/halt.
// Controls are zero-latency combinational from state and inputs; StallF/StallD are the upstream backpressure.
module fetch_hazard_ctrl #(
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic        ResultSrcE0,
  input  logic [4:0]  RdE,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic        halt_req,
  output logic        halt_ack,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [3:0] BOOT_LD  = 4'(BOOT_CYCLES);
  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        lw_stall;

`ifndef FETCH_HALT_EN
  logic halt_unused;
  assign halt_unused = halt_req;
`endif

  always_comb begin
    lw_stall = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

    state_d  = state_q;
    cnt_d    = cnt_q;
    StallF   = 1'b0;
    StallD   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    halt_ack = 1'b0;

    case (state_q)
      ST_BOOT: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RUN: begin
        // A taken branch squashes the load consumer anyway, so it overrides the stall.
        StallF = lw_stall & ~PCSrcE;
        StallD = lw_stall & ~PCSrcE;
        FlushD = PCSrcE;
        FlushE = PCSrcE | lw_stall;
`ifdef FETCH_HALT_EN
        if (halt_req && !PCSrcE) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LD;
        end
`endif
      end
`ifdef FETCH_HALT_EN
      ST_DRAIN: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
        if (!halt_req) begin
          state_d = ST_RUN;
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_HALT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HALT: begin
        StallF   = 1'b1;
        StallD   = 1'b1;
        FlushE   = 1'b1;
        halt_ack = 1'b1;
        if (!halt_req) begin
          state_d = ST_RUN;
        end
      end
`endif
      default: begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        FlushD  = 1'b1;
        FlushE  = 1'b1;
        state_d = ST_BOOT;
        cnt_d   = BOOT_LD;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_RUN && StallF && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_BOOT;
      cnt_q       <= BOOT_LD;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule
